seq_divider: RTL
================

// Module: seq_divider
// PURPOSE
//  Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU; the inverse of the shift-add multiplier.
//  Sits beside the multiplier in the EX stage; the pipeline stalls while busy=1.
//  Yields one quotient bit per cycle through a 33-bit subtract stage.
//  Resolves divide-by-zero and signed overflow in one cycle per the RISC-V spec.
// PARAMETERS
//  XLEN  32  operand/result width; only 32 is supported and verified
// PORTS
//  Clk       in   1     single clock, rising edge
//  Reset_n   in   1     asynchronous active-low reset
//  start     in   1     request; sampled only in IDLE
//  op        in   2     div_op_t = funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//  a         in   32    dividend
//  b         in   32    divisor
//  flush     in   1     abort the in-flight op (branch mispredict/trap)
//  busy      out  1     high from the cycle after start is accepted until done
//  done      out  1     single-cycle pulse; result valid this cycle
//  result    out  32    quotient or remainder; held until the next accepted start
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, result=0; all internal registers cleared.
//  States and transitions:
//   IDLE  -> start=1: latch op, |a|, |b|, sign flags.
//            Goes to DONE if b==0 or overflow; otherwise goes to RUN with cnt=31.
//   RUN   -> one step per cycle: rem={rem[31:0],dvd[31]}, dvd<<=1.
//            diff=rem-{1'b0,|b|}; if diff[32]==0 then rem=diff and qbit=1, else qbit=0.
//            Go to FIX when cnt==0; cnt decrements each step.
//   FIX   -> negate q if sign(a)^sign(b); negate r if sign(a) (signed ops only).
//            Select q or r into result. Go to DONE.
//   DONE  -> done=1 for exactly one cycle. Go to IDLE.
//  Latency, normal path: start sampled at edge 0, done high after edge 34 (32 RUN + FIX + DONE).
//  Latency, special cases: done high after edge 1.
//  busy=1 in RUN/FIX/DONE. start is ignored while not in IDLE.
//  A new start is accepted in the cycle after done.
//  Divide-by-zero: quotient=32'hFFFF_FFFF; remainder=a (both signed and unsigned).
//  Overflow (DIV/REM, a=32'h8000_0000, b=32'hFFFF_FFFF): quotient=32'h8000_0000, remainder=0.
//  Signed magnitudes: |a| for a=32'h8000_0000 is 32'h8000_0000, computed in 33-bit unsigned.
//  flush in RUN/FIX/DONE: the next state is IDLE, busy=0, and no done pulse is generated.
//   result keeps its old value. flush in IDLE has no effect.
//  flush and start in the same IDLE cycle: start wins.
//  Reset asserted mid-operation: immediate return to IDLE with all outputs 0.
// CONFIGURATION
//  DIV_EARLY_OUT_EN defined:
//   If |a|<|b| (unsigned, after abs), IDLE goes straight to FIX with q=0, r=|a|.
//   done is then high after edge 2.
//  DIV_EARLY_OUT_EN undefined:
//   Such operands take the full 32-step path; results are identical.
// STRUCTURE
//  Package div_pkg:
//   div_op_t enum (DIV, DIVU, REM, REMU)
//   div_state_t enum (IDLE, RUN, FIX, DONE)
//   DIV_STEPS=32
//   localparams for the overflow and div-by-zero constants
//  Sub-module div_sub33: combinational 33-bit rem-{1'b0,d}; outputs diff[32:0] and borrow.
//   Instanced once, in RUN.
//  Top level: FSM, 5-bit cnt, rem/dvd/q/|b| registers, sign fix-up, result mux.
// TESTING
//  DIVU a=100 b=7 -> result=14 after edge 34; REMU same operands -> 2; busy high for 34 cycles.
//  DIV a=-7 b=2 -> 32'hFFFF_FFFD; REM a=-7 b=2 -> 32'hFFFF_FFFF; REM a=7 b=-2 -> 1.
//  DIV a=32'h1234 b=0 -> 32'hFFFF_FFFF after edge 1; REMU a=32'h1234 b=0 -> 32'h1234.
//  DIV a=32'h8000_0000 b=32'hFFFF_FFFF -> 32'h8000_0000 after edge 1.
//   REM with the same operands -> 0.
//   DIVU with the same operands -> 0 (full path, or early-out when the macro is defined).
//  flush at RUN cycle 10 -> busy=0 next cycle, no done, result unchanged.
//   A following DIVU 9/3 -> 3.
//  Reset_n pulsed low mid-RUN -> outputs 0 asynchronously.
//   After reset release, a back-to-back start right after done is accepted and produces a correct result.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the seq_divider block.
// Holds the op/state enums, step count, special-case results and abs helper.
package div_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } div_state_t;

  localparam int DIV_STEPS = 32;

  localparam logic [31:0] DZ_Q  = 32'hFFFF_FFFF;
  localparam logic [31:0] OVF_A = 32'h8000_0000;
  localparam logic [31:0] OVF_B = 32'hFFFF_FFFF;
  localparam logic [31:0] OVF_Q = 32'h8000_0000;
  localparam logic [31:0] OVF_R = 32'h0000_0000;

  // Magnitude in 33 bits so 32'h8000_0000 maps to itself.
  function automatic logic [31:0] abs33(
    input logic [31:0] v,
    input logic        neg
  );
    logic [32:0] t;
    t = {v[31], v};
    if (neg) t = -t;
    return t[31:0];
  endfunction

endpackage

// File: rtl/div_sub33.sv
// div_sub33: combinational 33-bit trial subtract rem - {1'b0,d}.
// Ports: rem[32:0], d[31:0] in; diff[32:0] and borrow out.
module div_sub33 (
  input  logic [32:0] rem,
  input  logic [31:0] d,
  output logic [32:0] diff,
  output logic        borrow
);

  assign {borrow, diff} = {1'b0, rem} - {2'b00, d};

endmodule

// File: rtl/seq_divider.sv
// seq_divider: radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Ports: Clk, Reset_n, start, op, a, b, flush in; busy, done, result out.
// Optional: define DIV_EARLY_OUT_EN to skip the loop when |a| < |b|.
module seq_divider
  import div_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  div_state_t  r_state;
  div_state_t  w_state_nx;
  div_op_t     r_op;
  logic [4:0]  r_cnt;
  logic [31:0] r_rem;
  logic [31:0] r_dvd;
  logic [31:0] r_q;
  logic [31:0] r_absb;
  logic [31:0] r_pend;
  logic [31:0] r_result;
  logic        r_sa;
  logic        r_sb;
  logic        r_done;

  logic        w_sgn;
  logic        w_sa;
  logic        w_sb;
  logic        w_dz;
  logic        w_ovf;
  logic        w_special;
  logic        w_accept;
  logic        w_early;
  logic [31:0] w_absa;
  logic [31:0] w_absb;
  logic [31:0] w_spec_res;
  logic [31:0] w_qfix;
  logic [31:0] w_rfix;
  logic [32:0] w_shift;
  logic [32:0] w_diff;
  logic        w_borrow;
  logic        w_qbit;

  assign w_sgn  = ~op[0];
  assign w_sa   = w_sgn & a[31];
  assign w_sb   = w_sgn & b[31];
  assign w_absa = abs33(a, w_sa);
  assign w_absb = abs33(b, w_sb);

  assign w_dz  = (b == '0);
  assign w_ovf = w_sgn & (a == OVF_A)
               & (b == OVF_B);
  assign w_special = w_dz | w_ovf;

  always_comb begin
    w_spec_res = '0;
    unique case (1'b1)
      w_dz & ~op[1]:  w_spec_res = DZ_Q;
      w_dz &  op[1]:  w_spec_res = a;
      w_ovf & ~op[1]: w_spec_res = OVF_Q;
      default:        w_spec_res = OVF_R;
    endcase
  end

`ifdef DIV_EARLY_OUT_EN
  assign w_early = (w_absa < w_absb);
`else
  assign w_early = 1'b0;
`endif

  // The done cycle sits in IDLE; hold off a new start until it has passed.
  assign w_accept = (r_state == IDLE)
                  & start & ~r_done;

  assign w_shift = {r_rem, r_dvd[31]};

  div_sub33 u_sub (
    .rem    (w_shift),
    .d      (r_absb),
    .diff   (w_diff),
    .borrow (w_borrow)
  );

  // Only a difference that fits the 32-bit remainder is a valid step.
  assign w_qbit = ~(w_borrow | w_diff[32]);

  assign w_qfix = (r_sa ^ r_sb) ? -r_q : r_q;
  assign w_rfix = r_sa ? -r_rem : r_rem;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= IDLE;
    else          r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_special)    w_state_nx = DONE;
          else if (w_early) w_state_nx = FIX;
          else              w_state_nx = RUN;
        end
      end
      RUN: begin
        if (flush)             w_state_nx = IDLE;
        else if (r_cnt == '0)  w_state_nx = FIX;
      end
      FIX: begin
        if (flush) w_state_nx = IDLE;
        else       w_state_nx = DONE;
      end
      DONE:    w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_op     <= DIV;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_dvd    <= '0;
      r_q      <= '0;
      r_absb   <= '0;
      r_pend   <= '0;
      r_result <= '0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= (r_state == DONE) & ~flush;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op   <= div_op_t'(op);
            r_sa   <= w_sa;
            r_sb   <= w_sb;
            r_absb <= w_absb;
            r_dvd  <= w_absa;
            r_q    <= '0;
            r_cnt  <= 5'(DIV_STEPS - 1);
            r_rem  <= w_early ? w_absa : '0;
            if (w_special) r_pend <= w_spec_res;
          end
        end
        RUN: begin
          if (!flush) begin
            r_rem <= w_qbit ? w_diff[31:0]
                            : w_shift[31:0];
            r_dvd <= {r_dvd[30:0], 1'b0};
            r_q   <= {r_q[30:0], w_qbit};
            r_cnt <= r_cnt - 5'd1;
          end
        end
        FIX: begin
          if (!flush) begin
            r_pend <= r_op[1] ? w_rfix : w_qfix;
          end
        end
        DONE: begin
          if (!flush) r_result <= r_pend;
        end
        default: ;
      endcase
    end
  end

  assign busy   = (r_state != IDLE);
  assign done   = r_done;
  assign result = r_result;

endmodule
